// File: rtl/enable_gen_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// enable_gen_if : run-control and enable-strobe bundle for enable_gen
// Revision      : 1.0
// ---------------------------------------------------------------------------
interface enable_gen_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             stop;
  logic [1:0]       mode;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] count;
  logic             enb;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, mode, period, count,
    input  enb, busy, done
  );

  modport slave (
    input  start, stop, mode, period, count,
    output enb, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/enable_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// enable_gen : programmable enable-strobe generator for a clock-gating AND
// Revision   : 1.0
// ---------------------------------------------------------------------------
module enable_gen #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  enable_gen_if.slave bus
);
  localparam logic [1:0]       S_IDLE  = 2'd0;
  localparam logic [1:0]       S_RUN   = 2'd1;
  localparam logic [1:0]       S_DONE  = 2'd2;
  localparam logic [1:0]       M_CONT  = 2'b00;
  localparam logic [1:0]       M_BURST = 2'b01;
  localparam logic [WIDTH-1:0] C_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic             cont_q,  cont_d;
  logic [WIDTH-1:0] pm1_q,   pm1_d;
  logic [WIDTH-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] div_q,   div_d;
  logic [WIDTH-1:0] pcnt_q,  pcnt_d;
  logic             enb_q;

  logic             pulse;
  logic             last;
  logic             busy;
  logic             done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cont_q  <= 1'b0;
      pm1_q   <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cont_q  <= cont_d;
      pm1_q   <= pm1_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pcnt_q  <= pcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cont_d  = cont_q;
    pm1_d   = pm1_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cont_d  = (bus.mode == M_CONT);
          pm1_d   = (bus.period == '0) ? '0 : bus.period - C_ONE;
          // Single-pulse modes reuse the burst path with a count of one.
          cnt_d   = bus.mode[1] ? C_ONE : bus.count;
          div_d   = '0;
          pcnt_d  = '0;
          state_d = (bus.mode == M_BURST && bus.count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else begin
          div_d = pulse ? '0 : div_q + C_ONE;
          if (pulse) begin
            pcnt_d = pcnt_q + C_ONE;
          end
          if (last) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pulse = (state_q == S_RUN) && (div_q == pm1_q);
    last  = pulse && !cont_q && (pcnt_q == cnt_q - C_ONE);
    busy  = (state_q == S_RUN);
    done  = (state_q == S_DONE);
  end

  // Falling-edge retiming keeps enb stable for the whole clk high phase.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      enb_q <= 1'b0;
    end else begin
      enb_q <= pulse;
    end
  end

  assign bus.enb  = enb_q;
  assign bus.busy = busy;
  assign bus.done = done;
endmodule
`default_nettype wire

// File: tb/tb_enable_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_enable_gen : scoreboard bench for enable_gen (eclk pulses and done)
// Revision      : 1.0
// ---------------------------------------------------------------------------
module tb_enable_gen;
  logic clk   = 1'b0;
  logic reset = 1'b0;

  enable_gen_if #(.WIDTH(8)) bus ();
  enable_gen #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit kind;   // 0 = eclk high phase starting at cycle, 1 = done high in cycle
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc      = 0;
  int  checks   = 0;
  int  failures = 0;
  time t_rise   = 0;
  logic eclk;

  assign eclk = clk & bus.enb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_ev(input bit kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic score(input bit kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s: got event at cycle %0d, required none",
               kind ? "done" : "eclk", cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        failures++;
        $display("FAIL event: got kind=%0d cycle=%0d, required kind=%0d cycle=%0d",
                 kind, cyc, e.kind, e.cyc);
      end
    end
  endtask

  // Monitor: every posedge starts cycle cyc; enb sampled here covers that high phase.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!reset) begin
        if (bus.enb === 1'b1) score(1'b0);
        if (bus.done === 1'b1) score(1'b1);
      end
    end
  end

  always @(bus.enb) begin
    if (!reset && $time > 0) check("enb_change_clk_low", {31'd0, clk}, 32'd0);
  end

  always @(posedge eclk) t_rise = $time;
  always @(negedge eclk) begin
    if (!reset) check("eclk_width", 32'($time - t_rise), 32'd5);
  end

  task automatic run_cont(input logic [7:0] per, input int n);
    int t0;
    int pe;
    pe = (per == 8'd0) ? 1 : int'(per);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'b00; bus.period = per; bus.count = 8'd0;
    t0 = cyc + 1;
    for (int k = 1; k * pe <= n; k++) expect_ev(1'b0, t0 + k * pe);
    @(negedge clk);
    bus.start = 1'b0;
    check("cont_busy_on", {31'd0, bus.busy}, 32'd1);
    repeat (n - 1) @(negedge clk);
    check("cont_busy_before_stop", {31'd0, bus.busy}, 32'd1);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check("cont_busy_after_stop", {31'd0, bus.busy}, 32'd0);
    repeat (2 * pe + 2) @(negedge clk);
    check("cont_drained", exp_q.size(), 32'd0);
  endtask

  task automatic run_burst(input logic [1:0] m, input logic [7:0] per, input logic [7:0] cnt,
                           input bit poke, input bit stop_too);
    int t0;
    int pe;
    int n;
    pe = (per == 8'd0) ? 1 : int'(per);
    n  = m[1] ? 1 : int'(cnt);
    @(negedge clk);
    bus.start = 1'b1; bus.stop = stop_too; bus.mode = m; bus.period = per; bus.count = cnt;
    t0 = cyc + 1;
    for (int k = 1; k <= n; k++) expect_ev(1'b0, t0 + k * pe);
    expect_ev(1'b1, t0 + n * pe);
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    check("burst_busy", {31'd0, bus.busy}, (n != 0) ? 32'd1 : 32'd0);
    if (poke) begin
      repeat (3) @(negedge clk);
      bus.start = 1'b1; bus.mode = 2'b00; bus.period = 8'd1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    repeat (n * pe + 2) @(negedge clk);
    check("burst_idle", {31'd0, bus.busy}, 32'd0);
    check("burst_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    int t0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 2'b00;
    bus.period = 8'd0; bus.count = 8'd0;

    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_enb",  {31'd0, bus.enb},  32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_busy", {31'd0, bus.busy}, 32'd0);

    run_cont(8'd4, 10);
    run_burst(2'b01, 8'd3, 8'd5, 1'b1, 1'b0);
    run_cont(8'd0, 10);
    run_burst(2'b01, 8'd7, 8'd0, 1'b0, 1'b0);
    run_burst(2'b10, 8'd5, 8'd9, 1'b0, 1'b1);
    run_burst(2'b11, 8'd2, 8'd7, 1'b0, 1'b0);
    run_burst(2'b01, 8'd1, 8'd3, 1'b0, 1'b0);
    run_burst(2'b01, 8'd1, 8'd255, 1'b0, 1'b0);

    // Reset in the middle of a burst while enb is high.
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'b01; bus.period = 8'd2; bus.count = 8'd10;
    t0 = cyc + 1;
    for (int k = 1; k <= 3; k++) expect_ev(1'b0, t0 + 2 * k);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    #1;
    check("midburst_enb_high", {31'd0, bus.enb}, 32'd1);
    reset = 1'b1;
    #1;
    check("midburst_enb_drop",  {31'd0, bus.enb},  32'd0);
    check("midburst_busy_drop", {31'd0, bus.busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("midburst_drained", exp_q.size(), 32'd0);
    run_burst(2'b01, 8'd2, 8'd10, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
